// File: rtl/arb_stream_buffer.sv
// Word buffer between the arbiter and the SRAM FIFO: first-word-fall-through storage,
// hysteretic near-full throttle flag, and loss / occupancy statistics.
module arb_stream_buffer #(
   parameter int DEPTH  = 16,
   parameter int NF_SET = 12,
   parameter int NF_CLR = 8
) (
   input  logic                     i_bus_clk,
   input  logic                     i_bus_rst,
   input  logic                     i_write_in,
   input  logic [31:0]              i_data_in,
   output logic                     o_ready_out,
   input  logic                     i_fifo_read_next,
   output logic                     o_fifo_empty,
   output logic [31:0]              o_fifo_data,
   output logic                     o_near_full,
   input  logic                     i_clear_stats,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic [$clog2(DEPTH):0]   o_max_level,
   output logic [15:0]              o_lost_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic {IDLE, THROTTLE} nf_state_t;

   logic [31:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [LW-1:0] r_level;
   logic [LW-1:0] r_max_level;
   logic [15:0]   r_lost_cnt;
   nf_state_t     r_state;

   logic          w_full;
   logic          w_empty;
   logic          w_wr;
   logic          w_rd;
   logic          w_lost;
   logic [LW-1:0] w_level_nxt;
   nf_state_t     w_state_nxt;

   assign w_full  = (r_level == LW'(DEPTH));
   assign w_empty = (r_level == '0);
   assign w_wr    = i_write_in & ~w_full;
   assign w_rd    = i_fifo_read_next & ~w_empty;
   assign w_lost  = i_write_in & w_full;

   always_comb begin
      w_level_nxt = r_level;
      if (w_wr && !w_rd) begin
         w_level_nxt = r_level + LW'(1);
      end else if (!w_wr && w_rd) begin
         w_level_nxt = r_level - LW'(1);
      end
   end

   // Hysteresis thresholds are applied to the occupancy the buffer will hold after this edge.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:     if (w_level_nxt >= LW'(NF_SET)) w_state_nxt = THROTTLE;
         THROTTLE: if (w_level_nxt <= LW'(NF_CLR)) w_state_nxt = IDLE;
         default:  w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_bus_clk) begin
      if (w_wr) begin
         r_mem[r_wptr] <= i_data_in;
      end
   end

   always_ff @(posedge i_bus_clk) begin
      if (i_bus_rst) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_level     <= '0;
         r_max_level <= '0;
         r_lost_cnt  <= '0;
         r_state     <= IDLE;
      end else begin
         if (w_wr) r_wptr <= r_wptr + AW'(1);
         if (w_rd) r_rptr <= r_rptr + AW'(1);
         r_level <= w_level_nxt;
         r_state <= w_state_nxt;
         // A clear takes precedence over both a loss and a new high-water mark in the same cycle.
         if (i_clear_stats) begin
            r_lost_cnt  <= '0;
            r_max_level <= r_level;
         end else begin
            if (w_lost && (r_lost_cnt != 16'hFFFF)) r_lost_cnt <= r_lost_cnt + 16'd1;
            if (w_level_nxt > r_max_level) r_max_level <= w_level_nxt;
         end
      end
   end

   assign o_ready_out  = ~w_full;
   assign o_fifo_empty = w_empty;
   assign o_fifo_data  = r_mem[r_rptr];
   assign o_near_full  = (r_state == THROTTLE);
   assign o_level      = r_level;
   assign o_max_level  = r_max_level;
   assign o_lost_cnt   = r_lost_cnt;
endmodule

// File: tb/tb_arb_stream_buffer.sv
// Bench for arb_stream_buffer: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations and a randomized phase.
module tb_arb_stream_buffer;
   localparam int DEPTH  = 16;
   localparam int NF_SET = 12;
   localparam int NF_CLR = 8;
   localparam int LW     = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          win = 1'b0;
   logic [31:0]   din = '0;
   logic          rnext = 1'b0;
   logic          clr = 1'b0;
   logic          ready, empty, nf;
   logic [31:0]   dout;
   logic [LW-1:0] level, max_level;
   logic [15:0]   lost;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   logic [31:0] mq[$];
   int          m_max  = 0;
   int          m_lost = 0;
   bit          m_nf   = 1'b0;

   arb_stream_buffer #(.DEPTH(DEPTH), .NF_SET(NF_SET), .NF_CLR(NF_CLR)) dut (
      .i_bus_clk       (clk),
      .i_bus_rst       (rst),
      .i_write_in      (win),
      .i_data_in       (din),
      .o_ready_out     (ready),
      .i_fifo_read_next(rnext),
      .o_fifo_empty    (empty),
      .o_fifo_data     (dout),
      .o_near_full     (nf),
      .i_clear_stats   (clr),
      .o_level         (level),
      .o_max_level     (max_level),
      .o_lost_cnt      (lost)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: occupancy is simply the queue size.
   always @(posedge clk) begin
      int  lvl0;
      bit  wr, rd;
      if (rst) begin
         mq.delete();
         m_max  = 0;
         m_lost = 0;
         m_nf   = 1'b0;
      end else begin
         lvl0 = mq.size();
         wr   = win && (lvl0 != DEPTH);
         rd   = rnext && (lvl0 != 0);
         if (rd) void'(mq.pop_front());
         if (wr) mq.push_back(din);
         if (!m_nf && mq.size() >= NF_SET) m_nf = 1'b1;
         else if (m_nf && mq.size() <= NF_CLR) m_nf = 1'b0;
         if (clr) begin
            m_lost = 0;
            m_max  = lvl0;
         end else begin
            if (win && lvl0 == DEPTH && m_lost < 16'hFFFF) m_lost++;
            if (mq.size() > m_max) m_max = mq.size();
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ready", ready, mq.size() != DEPTH);
         chk("empty", empty, mq.size() == 0);
         chk("level", level, mq.size());
         chk("max_level", max_level, m_max);
         chk("lost_cnt", lost, m_lost);
         chk("near_full", nf, m_nf);
         if (mq.size() != 0) chk("fifo_data", dout, mq[0]);
      end
   end

   task automatic drive(input bit w, input logic [31:0] d, input bit r, input bit c, input bit rs);
      win = w; din = d; rnext = r; clr = c; rst = rs;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      do_reset();
      chk_en = 1'b1;
      do_reset();
      idle();
      chk("rst_level", level, 0);
      chk("rst_empty", empty, 1);
      chk("rst_ready", ready, 1);
      chk("rst_nf", nf, 0);
      chk("rst_lost", lost, 0);
      chk("rst_max", max_level, 0);

      // Five words in, then drain with read held high.
      for (int i = 1; i <= 5; i++) drive(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         chk("seq5_data", dout, i);
         chk("seq5_not_empty", empty, 0);
         drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      end
      chk("seq5_empty", empty, 1);
      chk("seq5_max", max_level, 5);

      // Fill past full, watching the throttle flag rise at 12.
      do_reset();
      for (int k = 1; k <= 16; k++) begin
         drive(1'b1, 32'hA000_0000 + 32'(k), 1'b0, 1'b0, 1'b0);
         chk("fill_nf", nf, (k >= 12) ? 1 : 0);
      end
      chk("full_ready", ready, 0);
      drive(1'b1, 32'hDEAD_0017, 1'b0, 1'b0, 1'b0);
      chk("full_lost", lost, 1);
      chk("full_level", level, 16);
      chk("full_head", dout, 32'hA000_0001);
      drive(1'b1, 32'hDEAD_0018, 1'b1, 1'b0, 1'b0);
      chk("fullpop_level", level, 15);
      chk("fullpop_lost", lost, 2);
      chk("fullpop_ready", ready, 1);
      chk("fullpop_head", dout, 32'hA000_0002);
      for (int k = 0; k < 6; k++) drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("drain9_level", level, 9);
      chk("drain9_nf", nf, 1);
      drive(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("drain8_level", level, 8);
      chk("drain8_nf", nf, 0);
      chk("drain_max", max_level, 16);

      // Reset mid-stream, then clear during a lost write.
      do_reset();
      for (int k = 0; k < 10; k++) drive(1'b1, 32'(k), 1'b0, 1'b0, 1'b0);
      drive(1'b1, 32'h55, 1'b1, 1'b1, 1'b1);
      chk("rstmid_level", level, 0);
      chk("rstmid_empty", empty, 1);
      chk("rstmid_nf", nf, 0);
      chk("rstmid_max", max_level, 0);
      for (int k = 0; k < 16; k++) drive(1'b1, 32'(k), 1'b0, 1'b0, 1'b0);
      drive(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
      chk("lost_before_clr", lost, 1);
      drive(1'b1, 32'h78, 1'b0, 1'b1, 1'b0);
      chk("clr_lost", lost, 0);
      chk("clr_level", level, 16);
      chk("clr_nf", nf, 1);

      // Streaming write+read from empty: pointer wraps many times, no bubbles.
      do_reset();
      drive(1'b1, 32'h1000, 1'b1, 1'b0, 1'b0);
      chk("stream_first_level", level, 1);
      for (int i = 1; i < 1000; i++) begin
         chk("stream_data", dout, 32'h1000 + 32'(i - 1));
         chk("stream_level", level, 1);
         drive(1'b1, 32'h1000 + 32'(i), 1'b1, 1'b0, 1'b0);
      end
      chk("stream_lost", lost, 0);
      chk("stream_max", max_level, 1);

      // Randomized phases: filling, draining, balanced; occasional clear and reset.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         int  ph;
         bit  w, r, c, rs;
         ph = (i / 200) % 3;
         case (ph)
            0:       begin w = ($urandom_range(0, 9) < 8); r = ($urandom_range(0, 9) < 3); end
            1:       begin w = ($urandom_range(0, 9) < 3); r = ($urandom_range(0, 9) < 8); end
            default: begin w = $urandom_range(0, 1) == 1; r = $urandom_range(0, 1) == 1; end
         endcase
         c  = ($urandom_range(0, 99) == 0);
         rs = ($urandom_range(0, 499) == 0);
         drive(w, $urandom, r, c, rs);
      end
      idle();
      chk_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/arb_stream_buffer.md
ARB_STREAM_BUFFER -- requirements
Module: arb_stream_buffer

Sits between the arbiter output and the SRAM FIFO input. It buffers 32-bit words, drives near-full throttling and keeps loss/occupancy statistics.

Interface
REQ-001 Parameter DEPTH, 16, buffer depth in words; SHALL be a power of 2, range 4..256.
REQ-002 Parameter NF_SET, 12, occupancy at or above which NEAR_FULL SHALL assert.
REQ-003 Parameter NF_CLR, 8, occupancy at or below which NEAR_FULL SHALL deassert; NF_CLR < NF_SET <= DEPTH.
REQ-004 BUS_CLK  in  1  single clock; all logic on rising edge.
REQ-005 BUS_RST  in  1  synchronous, active-high reset.
REQ-006 WRITE_IN  in  1  upstream word valid (arbiter WRITE_OUT).
REQ-007 DATA_IN  in  32  upstream word (arbiter DATA_OUT).
REQ-008 READY_OUT  out  1  buffer accepts a word this cycle (to arbiter READY_OUT input).
REQ-009 FIFO_READ_NEXT  in  1  downstream pops head word (SRAM FIFO FIFO_READ_NEXT_OUT).
REQ-010 FIFO_EMPTY  out  1  no word available (to SRAM FIFO FIFO_EMPTY_IN).
REQ-011 FIFO_DATA  out  32  head word, first-word-fall-through.
REQ-012 NEAR_FULL  out  1  hysteretic throttle flag (to trigger veto).
REQ-013 CLEAR_STATS  in  1  single-cycle pulse; clears statistics.
REQ-014 LEVEL  out  clog2(DEPTH)+1  current occupancy.
REQ-015 MAX_LEVEL  out  clog2(DEPTH)+1  high-water mark of LEVEL.
REQ-016 LOST_CNT  out  16  words offered while READY_OUT=0.

Function
REQ-017 READY_OUT SHALL be combinational !full, where full = (LEVEL==DEPTH).
REQ-018 A write SHALL be accepted when WRITE_IN & READY_OUT; the word is stored at the write pointer and the pointer advances mod DEPTH.
REQ-019 A pop SHALL occur when FIFO_READ_NEXT & !FIFO_EMPTY; the read pointer advances mod DEPTH; FIFO_READ_NEXT while empty SHALL be ignored.
REQ-020 FIFO_EMPTY SHALL be (LEVEL==0). FIFO_DATA SHALL equal the oldest stored word whenever !FIFO_EMPTY, with no bubble between consecutive words; its value while empty is don't-care.
REQ-021 Write latency: an accepted word SHALL appear on FIFO_DATA with FIFO_EMPTY=0 in the cycle after acceptance.
REQ-022 LEVEL SHALL be updated as +1 on write-only, -1 on pop-only, and unchanged on simultaneous write and pop.
REQ-023 Full plus simultaneous pop: the write SHALL NOT be accepted, because READY_OUT=0 in that cycle; the pop proceeds.
REQ-024 Empty plus simultaneous write: the write SHALL be accepted and the pop ignored; next-cycle LEVEL=1.
REQ-025 NEAR_FULL state machine, registered:
- IDLE -> THROTTLE when the next-cycle LEVEL >= NF_SET.
- THROTTLE -> IDLE when the next-cycle LEVEL <= NF_CLR.
- NEAR_FULL=1 in THROTTLE.
REQ-026 LOST_CNT SHALL increment by 1 each cycle with WRITE_IN & !READY_OUT. It SHALL saturate at 16'hFFFF.
REQ-027 MAX_LEVEL SHALL be loaded with the next-cycle LEVEL whenever that value exceeds it.
REQ-028 CLEAR_STATS SHALL set LOST_CNT=0 and MAX_LEVEL=current LEVEL. A loss in the same cycle SHALL NOT be counted (clear wins). CLEAR_STATS SHALL NOT affect the FIFO contents or NEAR_FULL.
REQ-029 Pointers SHALL be clog2(DEPTH) bits wide and wrap naturally; occupancy SHALL be derived from LEVEL, never from pointer comparison alone.

Reset
REQ-030 On BUS_RST, the following SHALL take the stated values in the next cycle:
- LEVEL=0, MAX_LEVEL=0, LOST_CNT=0.
- pointers=0.
- NEAR_FULL=0 (IDLE).
- FIFO_EMPTY=1, READY_OUT=1.
REQ-031 Reset mid-stream SHALL discard all stored words. Reset SHALL override simultaneous WRITE_IN, FIFO_READ_NEXT and CLEAR_STATS. Storage RAM contents need not be cleared.

Verification
REQ-032 Write 0x00000001..0x00000005 on consecutive cycles with FIFO_READ_NEXT=0, then hold FIFO_READ_NEXT=1 -> FIFO_DATA=0x1..0x5 on consecutive cycles, FIFO_EMPTY=1 after the fifth pop, MAX_LEVEL=5.
REQ-033 DEPTH=16: write 17 words with no reads -> READY_OUT=0 after the 16th, LOST_CNT=1, LEVEL=16; one pop -> READY_OUT=1.
REQ-034 Defaults: fill to 12 -> NEAR_FULL=1; drain to 9 -> NEAR_FULL still 1; drain to 8 -> NEAR_FULL=0.
REQ-035 Continuous write and read from empty for 1000 cycles with incrementing data -> output sequence identical and gap-free, LEVEL stays at or below 1, LOST_CNT=0, pointer wrap exercised.
REQ-036 At LEVEL=16, assert WRITE_IN and FIFO_READ_NEXT together -> the pop occurs, the write is rejected, LEVEL=15, LOST_CNT increments.
REQ-037 Fill to 10, assert BUS_RST for one cycle while writing -> LEVEL=0, FIFO_EMPTY=1, NEAR_FULL=0; assert CLEAR_STATS during a lost write -> LOST_CNT=0.
